// File: rtl/nios_core_cpu_mul_pkg.sv
// rtl/nios_core_cpu_mul_pkg.sv - shared types and constants for the multiply sequencer
//   exports: mul_state_t (sequencer states), MUL_HALF_W, MUL_LAT_1STAGE, MUL_LAT_2STAGE
package nios_core_cpu_mul_pkg;

    // Width of one operand half; the cell multiplies 16x16 halves.
    localparam int MUL_HALF_W = 16;

    // Cycles from the accept edge to rsp_valid, counting the accept edge as the first.
    localparam int MUL_LAT_1STAGE = 3;
    localparam int MUL_LAT_2STAGE = 4;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        ADD1  = 3'd2,
        ADD2  = 3'd3,
        DONE  = 3'd4
    } mul_state_t;

endpackage

// File: rtl/nios_core_cpu_cpu_mul_sum.sv
// rtl/nios_core_cpu_cpu_mul_sum.sv - pipelined combine adder for the three partial products
//   in:  clk, reset (async, active-high), en1 (ADD1 stage), en2 (ADD2 stage), p1/p2/p3 partial products
//   out: sum = low 32 bits of p1 + ((p2 + p3) << 16), registered
module nios_core_cpu_cpu_mul_sum
    import nios_core_cpu_mul_pkg::*;
#(
    parameter int ADD_STAGES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        en1,
    input  logic        en2,
    input  logic [31:0] p1,
    input  logic [31:0] p2,
    input  logic [31:0] p3,
    output logic [31:0] sum
);

    // Cross terms share the same weight; the carry out of bit 31 would land
    // above bit 47 after the shift, so it is dropped here.
    logic [31:0] mid_sum;
    assign mid_sum = p2 + p3;

    if (ADD_STAGES == 2) begin : g_two_stage
        logic [31:0] s_lo;
        logic [31:0] s_mid;

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                s_lo  <= '0;
                s_mid <= '0;
                sum   <= '0;
            end else begin
                if (en1) begin
                    s_lo  <= p1;
                    s_mid <= mid_sum;
                end
                if (en2) begin
                    sum <= s_lo + (s_mid << MUL_HALF_W);
                end
            end
        end
    end else begin : g_one_stage
        // en2 is never raised by the sequencer in this configuration; it is
        // folded in so both configurations share one enable contract.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                sum <= '0;
            end else if (en1 | en2) begin
                sum <= p1 + (mid_sum << MUL_HALF_W);
            end
        end
    end

endmodule

// File: rtl/nios_core_cpu_cpu_mul_seq.sv
// rtl/nios_core_cpu_cpu_mul_seq.sv - multiply sequencer around the 16x16 multiplier cell
//   request:  req_valid/req_ready, req_src1/req_src2 operands, cancel (flush)
//   cell:     mul_src1/mul_src2 operands, mul_en capture enable, mul_p1/p2/p3 partial products
//   response: rsp_valid/rsp_ready, rsp_result (low 32 bits of A*B), busy
module nios_core_cpu_cpu_mul_seq
    import nios_core_cpu_mul_pkg::*;
#(
    parameter int ADD_STAGES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_src1,
    input  logic [31:0] req_src2,
    input  logic        cancel,
    output logic [31:0] mul_src1,
    output logic [31:0] mul_src2,
    output logic        mul_en,
    input  logic [31:0] mul_p1,
    input  logic [31:0] mul_p2,
    input  logic [31:0] mul_p3,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_result,
    output logic        busy
);

    mul_state_t state;
    logic       sum_en1;
    logic       sum_en2;

    // Handshake and cell controls decode straight from the state register.
    assign req_ready = (state == IDLE);
    assign busy      = (state != IDLE);
    assign mul_en    = (state == ISSUE);
    assign rsp_valid = (state == DONE);

    // Partial products are only meaningful in ADD1 (one cycle after ISSUE);
    // a flush in that cycle suppresses the update as well.
    assign sum_en1 = (state == ADD1) && !cancel;
    assign sum_en2 = (state == ADD2) && !cancel;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            mul_src1 <= '0;
            mul_src2 <= '0;
        end else if (cancel) begin
            // Flush wins over both handshakes; operands are left as they are.
            state <= IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        mul_src1 <= req_src1;
                        mul_src2 <= req_src2;
                        state    <= ISSUE;
                    end
                end
                ISSUE: state <= ADD1;
                ADD1:  state <= (ADD_STAGES == 2) ? ADD2 : DONE;
                ADD2:  state <= DONE;
                DONE: begin
                    if (rsp_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    nios_core_cpu_cpu_mul_sum #(
        .ADD_STAGES (ADD_STAGES)
    ) u_sum (
        .clk   (clk),
        .reset (reset),
        .en1   (sum_en1),
        .en2   (sum_en2),
        .p1    (mul_p1),
        .p2    (mul_p2),
        .p3    (mul_p3),
        .sum   (rsp_result)
    );

endmodule

// File: tb/tb_nios_core_cpu_cpu_mul_seq.sv
// tb/tb_nios_core_cpu_cpu_mul_seq.sv - directed bench for both adder depths of the multiply sequencer
module tb_nios_core_cpu_cpu_mul_seq;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic [1:0]       req_valid;
    logic [1:0]       req_ready;
    logic [1:0][31:0] req_src1;
    logic [1:0][31:0] req_src2;
    logic [1:0]       cancel;
    logic [1:0][31:0] mul_src1;
    logic [1:0][31:0] mul_src2;
    logic [1:0]       mul_en;
    logic [1:0]       rsp_valid;
    logic [1:0]       rsp_ready;
    logic [1:0][31:0] rsp_result;
    logic [1:0]       busy;

    int checks = 0;
    int errors = 0;

    // Instance 0 uses one adder stage, instance 1 uses two.
    for (genvar g = 0; g < 2; g++) begin : g_dut
        logic [31:0] p1_q;
        logic [31:0] p2_q;
        logic [31:0] p3_q;

        // Behavioural multiplier cell: products registered while mul_en is high.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                p1_q <= '0;
                p2_q <= '0;
                p3_q <= '0;
            end else if (mul_en[g]) begin
                p1_q <= {16'h0, mul_src1[g][15:0]}  * {16'h0, mul_src2[g][15:0]};
                p2_q <= {16'h0, mul_src1[g][15:0]}  * {16'h0, mul_src2[g][31:16]};
                p3_q <= {16'h0, mul_src1[g][31:16]} * {16'h0, mul_src2[g][15:0]};
            end
        end

        nios_core_cpu_cpu_mul_seq #(
            .ADD_STAGES (g + 1)
        ) u_dut (
            .clk        (clk),
            .reset      (reset),
            .req_valid  (req_valid[g]),
            .req_ready  (req_ready[g]),
            .req_src1   (req_src1[g]),
            .req_src2   (req_src2[g]),
            .cancel     (cancel[g]),
            .mul_src1   (mul_src1[g]),
            .mul_src2   (mul_src2[g]),
            .mul_en     (mul_en[g]),
            .mul_p1     (p1_q),
            .mul_p2     (p2_q),
            .mul_p3     (p3_q),
            .rsp_valid  (rsp_valid[g]),
            .rsp_ready  (rsp_ready[g]),
            .rsp_result (rsp_result[g]),
            .busy       (busy[g])
        );
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_state(input int d, input string tag);
        check({tag, "_req_ready"},  32'(req_ready[d]), 32'd1);
        check({tag, "_busy"},       32'(busy[d]),      32'd0);
        check({tag, "_mul_en"},     32'(mul_en[d]),    32'd0);
        check({tag, "_rsp_valid"},  32'(rsp_valid[d]), 32'd0);
        check({tag, "_rsp_result"}, rsp_result[d],     32'd0);
        check({tag, "_mul_src1"},   mul_src1[d],       32'd0);
        check({tag, "_mul_src2"},   mul_src2[d],       32'd0);
    endtask

    // Counts posedges from the accept edge (as 1) until rsp_valid is seen.
    task automatic wait_rsp(input int d, inout int lat);
        while (rsp_valid[d] !== 1'b1 && lat < 20) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
    endtask

    // One complete operation; operands are scrambled right after the accept
    // edge so any late sampling shows up in the result.
    task automatic op(input int d, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] exp_res, input int exp_lat, input string tag);
        int lat;
        @(negedge clk);
        check({tag, "_req_ready_pre"}, 32'(req_ready[d]), 32'd1);
        req_valid[d] = 1'b1;
        req_src1[d]  = a;
        req_src2[d]  = b;
        @(posedge clk);
        lat = 1;
        @(negedge clk);
        req_valid[d] = 1'b0;
        req_src1[d]  = ~a;
        req_src2[d]  = b ^ 32'h5a5a_5a5a;
        check({tag, "_mul_en_issue"}, 32'(mul_en[d]), 32'd1);
        wait_rsp(d, lat);
        check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        check({tag, "_result"}, rsp_result[d], exp_res);
        check({tag, "_mul_en_done"}, 32'(mul_en[d]), 32'd0);
        if (rsp_ready[d]) begin
            @(negedge clk);
            check({tag, "_req_ready_post"}, 32'(req_ready[d]), 32'd1);
            check({tag, "_rsp_valid_post"}, 32'(rsp_valid[d]), 32'd0);
        end
    endtask

    initial begin
        int lat;
        bit seen;

        reset     = 1'b1;
        req_valid = '0;
        req_src1  = '0;
        req_src2  = '0;
        cancel    = '0;
        rsp_ready = 2'b11;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_state(0, "rst0");
        check_reset_state(1, "rst1");
        reset = 1'b0;

        // Basic products, one adder stage.
        op(0, 32'd3, 32'd5, 32'h0000_000F, 3, "m3x5");
        op(0, 32'h0001_0003, 32'h0002_0005, 32'h000B_000F, 3, "mcross");
        op(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 3, "mones");
        op(0, 32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 3, "mwrap");

        // Backpressure in DONE with a competing request waiting.
        rsp_ready[0] = 1'b0;
        op(0, 32'h0000_1234, 32'h0000_0010, 32'h0001_2340, 3, "bp");
        req_valid[0] = 1'b1;
        req_src1[0]  = 32'd2;
        req_src2[0]  = 32'd3;
        repeat (10) begin
            @(posedge clk);
            @(negedge clk);
            check("bp_hold_valid", 32'(rsp_valid[0]), 32'd1);
            check("bp_hold_result", rsp_result[0], 32'h0001_2340);
            check("bp_hold_req_ready", 32'(req_ready[0]), 32'd0);
        end
        rsp_ready[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("bp_release_not_accepted", 32'(busy[0]), 32'd0);
        @(posedge clk);
        lat = 1;
        @(negedge clk);
        req_valid[0] = 1'b0;
        check("bp_next_accepted", 32'(busy[0]), 32'd1);
        wait_rsp(0, lat);
        check("bp_next_latency", 32'(lat), 32'd3);
        check("bp_next_result", rsp_result[0], 32'h0000_0006);
        @(negedge clk);

        // Flush during ISSUE: no response for the abandoned operation.
        req_valid[0] = 1'b1;
        req_src1[0]  = 32'd9;
        req_src2[0]  = 32'd9;
        @(posedge clk);
        @(negedge clk);
        req_valid[0] = 1'b0;
        check("cis_in_issue", 32'(mul_en[0]), 32'd1);
        cancel[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        cancel[0] = 1'b0;
        check("cis_busy", 32'(busy[0]), 32'd0);
        check("cis_req_ready", 32'(req_ready[0]), 32'd1);
        seen = 1'b0;
        repeat (6) begin
            @(posedge clk);
            @(negedge clk);
            if (rsp_valid[0]) seen = 1'b1;
        end
        check("cis_no_rsp", 32'(seen), 32'd0);

        // A request presented with cancel is refused.
        req_valid[0] = 1'b1;
        req_src1[0]  = 32'd4;
        req_src2[0]  = 32'd4;
        cancel[0]    = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid[0] = 1'b0;
        cancel[0]    = 1'b0;
        check("creq_not_accepted", 32'(busy[0]), 32'd0);

        // Flush during DONE, overriding a stalled response.
        rsp_ready[0] = 1'b0;
        op(0, 32'd5, 32'd5, 32'd25, 3, "cdone");
        cancel[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        cancel[0] = 1'b0;
        check("cdone_rsp_valid", 32'(rsp_valid[0]), 32'd0);
        check("cdone_busy", 32'(busy[0]), 32'd0);
        rsp_ready[0] = 1'b1;
        op(0, 32'd7, 32'd6, 32'h0000_002A, 3, "m7x6");

        // Asynchronous reset while in ADD1.
        @(negedge clk);
        req_valid[0] = 1'b1;
        req_src1[0]  = 32'h0000_FFFF;
        req_src2[0]  = 32'h0000_FFFF;
        @(posedge clk);
        @(negedge clk);
        req_valid[0] = 1'b0;
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        check_reset_state(0, "arst");
        @(negedge clk);
        reset = 1'b0;
        seen = 1'b0;
        repeat (5) begin
            @(posedge clk);
            @(negedge clk);
            if (rsp_valid[0]) seen = 1'b1;
        end
        check("arst_no_rsp", 32'(seen), 32'd0);
        op(0, 32'd2, 32'd2, 32'h0000_0004, 3, "m2x2");

        // Two adder stages: same values, one more cycle.
        op(1, 32'h0001_0003, 32'h0002_0005, 32'h000B_000F, 4, "s2cross");
        op(1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 4, "s2ones");
        op(1, 32'd7, 32'd6, 32'h0000_002A, 4, "s2m7x6");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/nios_core_cpu_cpu_mul_seq.md
Name: nios_core_cpu_cpu_mul_seq

Overview:
- Multiply sequencer and partial-product combiner for the Nios core.
- Sits around the 16x16 multiplier cell:
  - drives the cell's operand and enable inputs (upstream role);
  - consumes the cell's three registered partial products (p1 = a_lo*b_lo, p2 = a_lo*b_hi, p3 = a_hi*b_lo) and forms the low 32 bits of a 32x32 product (downstream role).
- Presents a valid/ready request and response interface to the execute pipeline.

Parameters:
- ADD_STAGES, 1, combine-adder pipeline depth. 1 = single register after the full sum. 2 = register p1 and (p2+p3) first, then the final sum.

Ports:
- clk  in  1  core clock
- reset  in  1  asynchronous, active-high reset
- req_valid  in  1  multiply request present
- req_ready  out  1  sequencer can accept a request
- req_src1  in  32  operand A
- req_src2  in  32  operand B
- cancel  in  1  pipeline flush; abandons any in-flight operation
- mul_src1  out  32  operand A to the multiplier cell
- mul_src2  out  32  operand B to the multiplier cell
- mul_en  out  1  multiplier cell register enable
- mul_p1  in  32  partial product a_lo*b_lo from the cell
- mul_p2  in  32  partial product a_lo*b_hi from the cell
- mul_p3  in  32  partial product a_hi*b_lo from the cell
- rsp_valid  out  1  result valid
- rsp_ready  in  1  consumer accepts the result
- rsp_result  out  32  low 32 bits of A*B
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset values: state=IDLE; mul_src1=0; mul_src2=0; mul_en=0; rsp_valid=0; rsp_result=0; busy=0; all internal sum registers=0. req_ready=1 after reset (it is combinational: 1 only in IDLE).
- FSM states: IDLE, ISSUE, ADD1, ADD2 (present only when ADD_STAGES=2), DONE.
  - IDLE: on req_valid & req_ready, latch req_src1/req_src2 into mul_src1/mul_src2, go to ISSUE.
  - ISSUE: mul_en=1 (combinational from state) for exactly one cycle; the cell captures its products at the end of this cycle. Next state ADD1.
  - ADD1:
    - ADD_STAGES=1: rsp_result <= p1 + ((p2 + p3) << 16), truncated to 32 bits; go to DONE.
    - ADD_STAGES=2: s_lo <= p1; s_mid <= (p2 + p3) mod 2^32; go to ADD2.
  - ADD2: rsp_result <= s_lo + (s_mid << 16), truncated; go to DONE.
  - DONE: rsp_valid=1. On rsp_ready, go to IDLE. rsp_result holds until the next operation overwrites it.
- Latency from the accept edge to rsp_valid=1: 3 cycles (ADD_STAGES=1) or 4 cycles (ADD_STAGES=2). Throughput: one operation per (latency + 1) cycles minimum, because a request is not accepted while in DONE.
- Arithmetic:
  - Unsigned and modulo 2^32. Carries above bit 31 are discarded.
  - Signedness does not affect the low word.
  - The p2+p3 carry into bit 32 is discarded before the shift.
- Backpressure: DONE holds rsp_valid and rsp_result stable indefinitely while rsp_ready=0.
- cancel:
  - Any state goes to IDLE on the next edge; rsp_valid drops the next cycle.
  - A request presented in the same cycle as cancel is not accepted.
  - cancel has priority over rsp_ready and over req_valid.
  - mul_src1/mul_src2 keep their values (don't-care) after cancel.
- mul_en is 0 in every state except ISSUE. Stale partial products are ignored outside ADD1.
- Reset mid-operation: asynchronous return to the reset values. No result is emitted for the aborted operation.
- req_src1/req_src2 are sampled only on the accept edge. Later changes have no effect.

Decomposition:
- Shared package nios_core_cpu_mul_pkg:
  - state enum (IDLE, ISSUE, ADD1, ADD2, DONE);
  - constant MUL_HALF_W=16;
  - latency constants for ADD_STAGES=1 and ADD_STAGES=2.
- One natural sub-module: nios_core_cpu_cpu_mul_sum, the combine adder.
  - Inputs: p1/p2/p3, stage enables.
  - Output: the 32-bit sum.
  - Internally pipelined per ADD_STAGES.
- The FSM stays in the top level.
- The bench instantiates the multiplier cell (or a behavioural model of it: products registered when mul_en=1, cleared on reset).

Test Plan:
- 3 * 5 with ADD_STAGES=1 and rsp_ready=1 -> rsp_valid exactly 3 cycles after accept; rsp_result=0x0000000F; req_ready returns the cycle after.
- 0x00010003 * 0x00020005 -> p1=15, p2=6, p3=5; rsp_result=0x000B000F. With ADD_STAGES=2: same value, latency 4.
- 0xFFFFFFFF * 0xFFFFFFFF -> rsp_result=0x00000001. Also 0x00010000 * 0x00010000 -> rsp_result=0x00000000 (wrap).
- Backpressure: rsp_ready=0 for 10 cycles in DONE -> rsp_valid and rsp_result stable; req_ready=0; a new req_valid is not accepted until the cycle after rsp_ready=1.
- cancel asserted in ISSUE, then in DONE -> IDLE next cycle; no rsp_valid pulse for the cancelled operation (first case); rsp_valid drops (second case). A following 7*6 returns 0x0000002A.
- reset pulsed in ADD1 -> all outputs equal their reset values immediately (asynchronous); mul_en=0; busy=0. The next operation, 2*2, returns 0x00000004.
